ps2_cmd_ctrl: RTL and testbench
===============================

PS2_CMD_CTRL -- requirements
Module: ps2_cmd_ctrl

Interface
REQ-001 Parameter CLK_MHZ, default 50, system clock frequency in MHz.
REQ-002 Parameter TIMEOUT_US, default 20000, ack timeout in microseconds; timeout cycles = CLK_MHZ*TIMEOUT_US.
REQ-003 Parameter MAX_RETRY, default 3, resends allowed per byte after 0xFE.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  host command request.
REQ-007 req_ready  out  1  controller can accept a request.
REQ-008 req_cmd  in  8  command byte.
REQ-009 req_has_arg  in  1  command carries one argument byte.
REQ-010 req_arg  in  8  argument byte.
REQ-011 done  out  1  one-cycle pulse: command (and arg) acknowledged.
REQ-012 err  out  1  one-cycle pulse: command aborted.
REQ-013 err_code  out  2  01 = retries exhausted, 10 = timeout; held until next accept.
REQ-014 tx_data  out  8  byte to PS/2 transmitter.
REQ-015 tx_start  out  1  one-cycle transmit strobe.
REQ-016 tx_busy  in  1  transmitter busy.
REQ-017 rx_code  in  8  byte received from PS/2 core.
REQ-018 rx_new  in  1  one-cycle strobe, rx_code valid.
REQ-019 scan_code  out  8  forwarded non-ack byte.
REQ-020 scan_valid  out  1  one-cycle strobe, scan_code valid.

Function
REQ-021 States: IDLE, SEND_CMD, WAIT_CMD, SEND_ARG, WAIT_ARG, DONE, ERROR.
REQ-022 req_ready SHALL be 1 only in IDLE; req_valid&&req_ready latches req_cmd/req_has_arg/req_arg, clears err_code, enters SEND_CMD next cycle.
REQ-023 SEND_x: while tx_busy=1 hold; when tx_busy=0 assert tx_start one cycle with tx_data = byte, load timeout counter, enter WAIT_x.
REQ-024 tx_data SHALL hold its value until the next tx_start.
REQ-025 WAIT_x, rx_new with 0xFA: WAIT_CMD with has_arg -> SEND_ARG (retry count cleared); otherwise -> DONE.
REQ-026 WAIT_x, rx_new with 0xFE: retry count +1; if new count <= MAX_RETRY -> SEND_x (same byte); else err_code=01 -> ERROR.
REQ-027 WAIT_x, rx_new with any other byte: forward as scan_code/scan_valid next cycle; state unchanged; timeout keeps counting.
REQ-028 WAIT_x, timeout counter reaches zero with no ack: err_code=10 -> ERROR.
REQ-029 0xFA/0xFE arriving in the same cycle as timeout expiry SHALL win over the timeout.
REQ-030 IDLE/SEND_x/DONE/ERROR: every rx_new byte, including stray 0xFA/0xFE, SHALL be forwarded to scan_code.
REQ-031 DONE: done=1 one cycle -> IDLE. ERROR: err=1 one cycle -> IDLE.
REQ-032 Retry count SHALL be 0 on entry to SEND_CMD from IDLE; width ceil(log2(MAX_RETRY+2)).
REQ-033 req_valid outside IDLE SHALL be ignored; latched command fields SHALL not change.

Reset
REQ-034 rst=0 SHALL asynchronously force IDLE, retry count 0, timeout counter 0, tx_data/scan_code 0x00, tx_start/done/err/scan_valid 0, err_code 00.
REQ-035 Reset mid-command SHALL abandon the command with no done/err pulse; req_ready=1 the first cycle after rst deasserts.

Configuration
REQ-036 Macro PS2_CMD_TIMEOUT_EN defined: timeout counter and REQ-028 compiled in.
REQ-037 Macro undefined: no counter; WAIT_x waits indefinitely for 0xFA/0xFE; err_code 10 never produced.

Verification
REQ-038 Accept cmd 0xFF no arg, tx_busy=0, reply 0xFA -> one tx_start with tx_data=0xFF, done pulse, req_ready=1 next cycle.
REQ-039 Cmd 0xED arg 0x07, replies 0xFA,0xFA -> tx_start 0xED then 0x07, single done, no scan_valid.
REQ-040 Cmd 0xF4, reply 0xFE four times (MAX_RETRY=3) -> four tx_start 0xF4, then err with err_code=01.
REQ-041 PS2_CMD_TIMEOUT_EN, CLK_MHZ=50, TIMEOUT_US=20, no reply -> err, err_code=10, exactly 1000 cycles after tx_start; without macro, no err after 5000 cycles.
REQ-042 In WAIT_CMD, rx 0x1C then 0xFA -> scan_valid with 0x1C, then done; rx 0xFA in IDLE -> scan_valid 0xFA.
REQ-043 rst=0 in WAIT_ARG -> outputs reset values immediately, no done/err; new request accepted after release.

Source files
------------

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host command controller: sends a command byte (and optional argument),
// handles 0xFA/0xFE replies with bounded resends, and forwards all other bytes.
// Optional ack timeout is compiled in when PS2_CMD_TIMEOUT_EN is defined.
module ps2_cmd_ctrl #(
    parameter int unsigned CLK_MHZ    = 50,
    parameter int unsigned TIMEOUT_US = 20000,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_cmd,
    input  logic       req_has_arg,
    input  logic [7:0] req_arg,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic [7:0] rx_code,
    input  logic       rx_new,
    output logic [7:0] scan_code,
    output logic       scan_valid
);

    localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        StIdle, StSendCmd, StWaitCmd, StSendArg, StWaitArg, StDone, StError
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d, arg_q, arg_d;
    logic              has_arg_q, has_arg_d;
    logic [RetryW-1:0] retry_q, retry_d, retry_inc;
    logic [7:0]        tx_data_q, tx_data_d, scan_code_q, scan_code_d;
    logic              tx_start_q, tx_start_d, scan_valid_q, scan_valid_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              in_wait, is_ack, is_nak;

`ifdef PS2_CMD_TIMEOUT_EN
    localparam int unsigned TimeoutCyc = CLK_MHZ * TIMEOUT_US;
    localparam int unsigned CntW       = $clog2(TimeoutCyc + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    assign in_wait   = (state_q == StWaitCmd) || (state_q == StWaitArg);
    assign is_ack    = rx_new && (rx_code == 8'hFA);
    assign is_nak    = rx_new && (rx_code == 8'hFE);
    assign retry_inc = retry_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        arg_d        = arg_q;
        has_arg_d    = has_arg_q;
        retry_d      = retry_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        scan_code_d  = scan_code_q;
        scan_valid_d = 1'b0;
        err_code_d   = err_code_q;
`ifdef PS2_CMD_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        // Acks and resends are consumed only while waiting; everything else is forwarded.
        if (rx_new && !(in_wait && (is_ack || is_nak))) begin
            scan_valid_d = 1'b1;
            scan_code_d  = rx_code;
        end

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    cmd_d      = req_cmd;
                    arg_d      = req_arg;
                    has_arg_d  = req_has_arg;
                    err_code_d = 2'b00;
                    retry_d    = '0;
                    state_d    = StSendCmd;
                end
            end
            StSendCmd, StSendArg: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = (state_q == StSendCmd) ? cmd_q : arg_q;
                    state_d    = (state_q == StSendCmd) ? StWaitCmd : StWaitArg;
`ifdef PS2_CMD_TIMEOUT_EN
                    cnt_d      = CntW'(TimeoutCyc);
`endif
                end
            end
            StWaitCmd, StWaitArg: begin
                if (is_ack) begin
                    if (state_q == StWaitCmd && has_arg_q) begin
                        retry_d = '0;
                        state_d = StSendArg;
                    end else begin
                        state_d = StDone;
                    end
                end else if (is_nak) begin
                    retry_d = retry_inc;
                    if (retry_inc <= RetryW'(MAX_RETRY)) begin
                        state_d = (state_q == StWaitCmd) ? StSendCmd : StSendArg;
                    end else begin
                        err_code_d = 2'b01;
                        state_d    = StError;
                    end
                end
`ifdef PS2_CMD_TIMEOUT_EN
                else if (cnt_q <= CntW'(1)) begin
                    cnt_d      = '0;
                    err_code_d = 2'b10;
                    state_d    = StError;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
`endif
            end
            StDone, StError: state_d = StIdle;
            default:         state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cmd_q        <= 8'h00;
            arg_q        <= 8'h00;
            has_arg_q    <= 1'b0;
            retry_q      <= '0;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            scan_code_q  <= 8'h00;
            scan_valid_q <= 1'b0;
            err_code_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            arg_q        <= arg_d;
            has_arg_q    <= has_arg_d;
            retry_q      <= retry_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            scan_code_q  <= scan_code_d;
            scan_valid_q <= scan_valid_d;
            err_code_q   <= err_code_d;
        end
    end

`ifdef PS2_CMD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign req_ready  = (state_q == StIdle);
    assign done       = (state_q == StDone);
    assign err        = (state_q == StError);
    assign err_code   = err_code_q;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign scan_code  = scan_code_q;
    assign scan_valid = scan_valid_q;

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Self-checking bench for ps2_cmd_ctrl: directed vector table, hand sequences for
// timeout/reset corners, and randomized transactions checked against a transaction model.
module tb_ps2_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid, req_ready, req_has_arg, done, err, tx_start, tx_busy;
    logic       rx_new, scan_valid;
    logic [7:0] req_cmd, req_arg, tx_data, rx_code, scan_code;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    ps2_cmd_ctrl #(.CLK_MHZ(50), .TIMEOUT_US(20), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_has_arg(req_has_arg), .req_arg(req_arg),
        .done(done), .err(err), .err_code(err_code), .tx_data(tx_data),
        .tx_start(tx_start), .tx_busy(tx_busy), .rx_code(rx_code), .rx_new(rx_new),
        .scan_code(scan_code), .scan_valid(scan_valid)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int tx_cyc = 0;
    int err_cyc = 0;
    logic [7:0] tx_q[$];
    logic [7:0] scan_q[$];
    logic [7:0] exp_scan[$];

    // Event monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (tx_start) begin
                    tx_q.push_back(tx_data);
                    tx_cyc = cyc;
                end
                if (scan_valid) scan_q.push_back(scan_code);
                if (done) done_cnt++;
                if (err) begin
                    err_cnt++;
                    err_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_code = b;
        rx_new  = 1'b1;
        tick();
        rx_new  = 1'b0;
    endtask

    task automatic wait_tx(input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (tx_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
            tx_busy = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
            tick();
        end
        tx_busy = 1'b0;
        if (!ok) check("tx_wait_timeout", 0, 1);
    endtask

    task automatic accept(input logic [7:0] c, input bit h, input logic [7:0] a);
        bit ok = 1'b0;
        req_cmd = c;
        req_has_arg = h;
        req_arg = a;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("accept_timeout", 0, 1);
        tick();
        req_valid = 1'b0;
    endtask

    // Replies with fe[phase] resends then an ack per phase; a 4th resend ends the command.
    task automatic run_txn(input logic [7:0] c, input bit h, input logic [7:0] a,
                           input int fe0, input int fe1, input bit rnd,
                           output int ntx, output int ndone, output int nerr);
        int base_d, base_e, phase, sent0, sent1, fe_cur, sent_cur;
        bit fin, ok;
        logic [7:0] b, j;
        base_d = done_cnt;
        base_e = err_cnt;
        tx_q.delete();
        scan_q.delete();
        exp_scan.delete();
        ntx = 0; phase = 0; sent0 = 0; sent1 = 0; fin = 1'b0;
        accept(c, h, a);
        while (!fin) begin
            wait_tx(rnd, ok);
            if (!ok) break;
            b = tx_q.pop_front();
            ntx++;
            check("tx_byte", b, (phase == 0) ? c : a);
            if (rnd) begin
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                    do j = 8'($urandom); while (j == 8'hFA || j == 8'hFE);
                    if ($urandom_range(0, 1) == 1) begin
                        req_valid = 1'b1;
                        req_cmd = 8'($urandom);
                        req_arg = 8'($urandom);
                        req_has_arg = 1'($urandom);
                    end
                    send_rx(j);
                    exp_scan.push_back(j);
                end
                req_valid = 1'b0;
            end
            fe_cur   = (phase == 0) ? fe0 : fe1;
            sent_cur = (phase == 0) ? sent0 : sent1;
            if (sent_cur < fe_cur) begin
                send_rx(8'hFE);
                if (phase == 0) sent0++; else sent1++;
                if (sent_cur + 1 == 4) fin = 1'b1;
            end else begin
                send_rx(8'hFA);
                if (phase == 0 && h) phase = 1; else fin = 1'b1;
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (done_cnt != base_d || err_cnt != base_e) break;
            tick();
        end
        ndone = done_cnt - base_d;
        nerr  = err_cnt - base_e;
        tick();
        check("ready_after_end", req_ready, 1);
        check("scan_count", scan_q.size(), exp_scan.size());
        for (int i = 0; i < exp_scan.size() && i < scan_q.size(); i++)
            check("scan_byte", scan_q[i], exp_scan[i]);
    endtask

    typedef struct {
        logic [7:0] cmd;
        bit         has;
        logic [7:0] arg;
        int         fe0;
        int         fe1;
        int         exp_tx;
        int         exp_done;
        int         exp_err;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int ntx, nd, ne, base_d, base_e, c0, etx, ed, ee;
        bit ok, h;
        logic [7:0] c, a, b;
        int f0, f1;

        vecs[0] = '{8'hFF, 1'b0, 8'h00, 0, 0, 1, 1, 0, 2'b00};
        vecs[1] = '{8'hED, 1'b1, 8'h07, 0, 0, 2, 1, 0, 2'b00};
        vecs[2] = '{8'hF4, 1'b0, 8'h00, 4, 0, 4, 0, 1, 2'b01};
        vecs[3] = '{8'hF3, 1'b1, 8'h0A, 2, 3, 7, 1, 0, 2'b00};
        vecs[4] = '{8'hED, 1'b1, 8'h02, 0, 4, 5, 0, 1, 2'b01};
        vecs[5] = '{8'hF2, 1'b0, 8'h00, 3, 0, 4, 1, 0, 2'b00};

        req_valid = 0; req_cmd = 0; req_has_arg = 0; req_arg = 0;
        tx_busy = 0; rx_code = 0; rx_new = 0;
        tick(); tick(); tick();
        check("rst_ready", req_ready, 1);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_scan", {scan_valid, scan_code}, 9'h000);
        check("rst_done_err", {done, err}, 2'b00);
        check("rst_err_code", err_code, 2'b00);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].cmd, vecs[i].has, vecs[i].arg, vecs[i].fe0, vecs[i].fe1, 1'b0,
                    ntx, nd, ne);
            check("vec_tx_count", ntx, vecs[i].exp_tx);
            check("vec_done", nd, vecs[i].exp_done);
            check("vec_err", ne, vecs[i].exp_err);
            check("vec_err_code", err_code, vecs[i].exp_code);
        end

        // Non-ack byte during WAIT_CMD is forwarded; ack still completes; stray ack in IDLE forwarded.
        tx_q.delete();
        accept(8'hF4, 1'b0, 8'h00);
        wait_tx(1'b0, ok);
        if (ok) void'(tx_q.pop_front());
        send_rx(8'h1C);
        check("wait_scan", {scan_valid, scan_code}, {1'b1, 8'h1C});
        send_rx(8'hFA);
        check("wait_ack_done", done, 1);
        check("wait_ack_no_scan", scan_valid, 0);
        tick();
        send_rx(8'hFA);
        check("idle_fa_scan", {scan_valid, scan_code}, {1'b1, 8'hFA});
        tick();

        base_e = err_cnt;
        base_d = done_cnt;
        tx_q.delete();
        accept(8'hF4, 1'b0, 8'h00);
        wait_tx(1'b0, ok);
        if (ok) void'(tx_q.pop_front());
        c0 = tx_cyc;
`ifdef PS2_CMD_TIMEOUT_EN
        for (int i = 0; i < 1100 && err_cnt == base_e; i++) tick();
        check("timeout_err", err_cnt - base_e, 1);
        check("timeout_latency", err_cyc - c0, 1000);
        check("timeout_code", err_code, 2'b10);
        tick();
        // Ack landing on the expiry cycle must win.
        base_e = err_cnt;
        tx_q.delete();
        accept(8'hF4, 1'b0, 8'h00);
        wait_tx(1'b0, ok);
        if (ok) void'(tx_q.pop_front());
        c0 = tx_cyc;
        while (cyc < c0 + 999) tick();
        send_rx(8'hFA);
        check("race_done", done, 1);
        check("race_no_err", err_cnt - base_e, 0);
        tick();
`else
        for (int i = 0; i < 5000; i++) tick();
        check("no_timeout_err", err_cnt - base_e, 0);
        send_rx(8'hFA);
        check("late_ack_done", done_cnt - base_d, 1);
        check("late_ack_code", err_code, 2'b00);
        tick();
`endif

        // Reset while waiting for the argument ack.
        tx_q.delete();
        accept(8'hED, 1'b1, 8'h07);
        wait_tx(1'b0, ok);
        if (ok) void'(tx_q.pop_front());
        send_rx(8'hFA);
        wait_tx(1'b0, ok);
        if (ok) b = tx_q.pop_front();
        check("arg_before_rst", b, 8'h07);
        base_d = done_cnt;
        base_e = err_cnt;
        rst = 1'b0;
        #1;
        check("arst_tx", {tx_start, tx_data}, 9'h000);
        check("arst_scan", {scan_valid, scan_code}, 9'h000);
        check("arst_ready", req_ready, 1);
        check("arst_done_err", {done, err, err_code}, 4'b0000);
        tick(); tick();
        rst = 1'b1;
        check("release_ready", req_ready, 1);
        tick();
        check("rst_no_pulse", (done_cnt - base_d) + (err_cnt - base_e), 0);
        run_txn(8'hF5, 1'b0, 8'h00, 0, 0, 1'b0, ntx, nd, ne);
        check("post_rst_txn", {ntx[7:0], nd[7:0], ne[7:0]}, {8'd1, 8'd1, 8'd0});

        // Randomized transactions against a count-based model.
        for (int t = 0; t < 40; t++) begin
            c = 8'($urandom);
            a = 8'($urandom);
            h = 1'($urandom);
            f0 = $urandom_range(0, 4);
            f1 = $urandom_range(0, 4);
            if (f0 == 4) begin
                etx = 4; ed = 0; ee = 1;
            end else if (!h) begin
                etx = f0 + 1; ed = 1; ee = 0;
            end else if (f1 == 4) begin
                etx = f0 + 1 + 4; ed = 0; ee = 1;
            end else begin
                etx = f0 + f1 + 2; ed = 1; ee = 0;
            end
            run_txn(c, h, a, f0, f1, 1'b1, ntx, nd, ne);
            check("rnd_tx_count", ntx, etx);
            check("rnd_done", nd, ed);
            check("rnd_err", ne, ee);
            check("rnd_err_code", err_code, ee ? 2'b01 : 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
